// File: rtl/reg_bank_wr.sv
// rtl/reg_bank_wr.sv - four-entry register bank write-back with ALU priority and 2-deep load buffer
module reg_bank_wr #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr1_en,
    input  logic [1:0]    wr1_addr,
    input  logic [DW-1:0] wr1_data,
    input  logic          wr2_valid,
    output logic          wr2_ready,
    input  logic [1:0]    wr2_addr,
    input  logic [DW-1:0] wr2_data,
    output logic [DW-1:0] bank0,
    output logic [DW-1:0] bank1,
    output logic [DW-1:0] bank2,
    output logic [DW-1:0] bank3,
    output logic [3:0]    pend
);

    logic [DW-1:0] bank_q [4];
    logic [1:0]    cnt;
    logic [1:0]    buf_addr [2];
    logic [DW-1:0] buf_data [2];

    logic          acc2, bypass, push, pop, keep0, keep1;
    logic          we;
    logic [1:0]    wa;
    logic [DW-1:0] wd;
    logic [1:0]    n_cnt;
    logic [1:0]    n_addr [2];
    logic [DW-1:0] n_data [2];

    assign wr2_ready = (cnt < 2'd2) && !rst;
    assign acc2      = wr2_valid && wr2_ready;
    assign pop       = !wr1_en && (cnt != 2'd0);
    assign bypass    = !wr1_en && (cnt == 2'd0) && acc2;
    // A same-cycle load to the ALU's destination is older in program order, so it is dropped.
    assign push      = acc2 && !bypass && !(wr1_en && (wr2_addr == wr1_addr));
    assign keep0     = (cnt != 2'd0) && !pop && !(wr1_en && (buf_addr[0] == wr1_addr));
    assign keep1     = (cnt == 2'd2) && !(wr1_en && (buf_addr[1] == wr1_addr));

    always_comb begin
        we = 1'b0;
        wa = wr1_addr;
        wd = wr1_data;
        if (wr1_en) begin
            we = 1'b1;
        end else if (cnt != 2'd0) begin
            we = 1'b1;
            wa = buf_addr[0];
            wd = buf_data[0];
        end else if (acc2) begin
            we = 1'b1;
            wa = wr2_addr;
            wd = wr2_data;
        end
    end

    // Rebuild the buffer compacted: surviving entries in order, then the new push.
    always_comb begin
        n_addr[0] = buf_addr[0];
        n_data[0] = buf_data[0];
        n_addr[1] = buf_addr[1];
        n_data[1] = buf_data[1];
        if (keep0) begin
            n_addr[0] = buf_addr[0];
            n_data[0] = buf_data[0];
        end
        if (keep1) begin
            if (keep0) begin
                n_addr[1] = buf_addr[1];
                n_data[1] = buf_data[1];
            end else begin
                n_addr[0] = buf_addr[1];
                n_data[0] = buf_data[1];
            end
        end
        if (push) begin
            if (keep0 || keep1) begin
                n_addr[1] = wr2_addr;
                n_data[1] = wr2_data;
            end else begin
                n_addr[0] = wr2_addr;
                n_data[0] = wr2_data;
            end
        end
        n_cnt = {1'b0, keep0} + {1'b0, keep1} + {1'b0, push};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_addr[i] <= '0;
                buf_data[i] <= '0;
            end
            cnt <= 2'd0;
        end else begin
            if (we) bank_q[wa] <= wd;
            buf_addr[0] <= n_addr[0];
            buf_data[0] <= n_data[0];
            buf_addr[1] <= n_addr[1];
            buf_data[1] <= n_data[1];
            cnt         <= n_cnt;
        end
    end

    always_comb begin
        pend = 4'b0000;
        if (cnt != 2'd0) pend[buf_addr[0]] = 1'b1;
        if (cnt == 2'd2) pend[buf_addr[1]] = 1'b1;
    end

    assign bank0 = bank_q[0];
    assign bank1 = bank_q[1];
    assign bank2 = bank_q[2];
    assign bank3 = bank_q[3];

endmodule

// File: doc/reg_bank_wr.md
# reg_bank_wr

Write-back side of the four-entry 8-bit register bank. Owns bank0..bank3 and commits results from two producers: the ALU (port 1, unconditional, highest priority) and the memory-load path (port 2, valid/ready handshake). Port-2 writes that collide with an ALU write are held in a 2-entry in-order buffer and drained on idle cycles. The bank outputs feed the read-select stage directly.

## Interface
- DW, 8, data width of every bank register and write port

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wr1_en  in  1  ALU write strobe; always accepted
- wr1_addr  in  2  ALU destination register
- wr1_data  in  DW  ALU result
- wr2_valid  in  1  load result valid
- wr2_ready  out  1  block can accept a port-2 write this cycle
- wr2_addr  in  2  load destination register
- wr2_data  in  DW  load data
- bank0..bank3  out  DW each  registered register contents
- pend  out  4  one-hot OR of destinations held in the buffer (bit n = register n has a queued write)

## Operation
- Reset: bank0..bank3 = 0, buffer empty (count 0), pend = 4'b0000, wr2_ready = 0 while rst is high.
- Port-2 accept: wr2_valid && wr2_ready. wr2_ready = (count < 2) && !rst.
- Bank write source each cycle, in priority order:
  1. wr1_en: bank[wr1_addr] <= wr1_data.
  2. Otherwise, buffer non-empty: head entry is written and popped.
  3. Otherwise, accepted port-2 write with buffer empty: written directly (bypass).
- An accepted port-2 write that is not committed this cycle is pushed at the buffer tail. Order among port-2 writes is always preserved. A new port-2 write never bypasses a non-empty buffer.
- Same-cycle push and pop is legal and leaves count unchanged.
- Kill rule: the ALU write is program-order newer than anything on port 2.
  - When wr1_en writes address A, every buffer entry with address A is invalidated in the same cycle.
  - A same-cycle accepted port-2 write to A is discarded.
  - Killed entries are removed and the remaining entries stay compacted in order.
- At most one bank register changes per cycle.
- count is 0..2. Overflow cannot occur because accepts are gated by ready.

## Timing
- ALU write: bank visible on the output the cycle after the wr1_en edge. Latency 1.
- Port-2 bypass: latency 1 from the accepting edge.
- Buffered port-2 write: commits on the first edge with wr1_en low and the entry at the head. Worst-case latency is unbounded under continuous wr1_en.
- pend and wr2_ready are combinational from registered state only. There is no combinational path from wr2_valid or wr1_* to either output.
- With the buffer full (count 2), wr2_ready = 0. It rises the cycle after a pop or kill frees an entry.
- Async rst mid-operation: buffer contents are lost and banks clear immediately. The first accept is possible on the first edge after rst deasserts.

## Test plan
- Reset, then wr1_en=1, addr=2, data=0x5A for 1 cycle -> bank2=0x5A next cycle, other banks 0, pend=0.
- Port-2 bypass: wr2 valid, addr=1, data=0x33, wr1_en=0 -> wr2_ready=1, bank1=0x33 next cycle, pend stays 0.
- Collision and drain: wr1 (0,0x11) with wr2 (3,0xC3) in the same cycle, then idle -> bank0=0x11; pend=4'b1000 for one cycle; bank3=0xC3 one cycle later; pend=0.
- Full buffer: hold wr1_en=1 to addr 0 and present wr2 to addr 1 (0xA1), then addr 2 (0xA2), then addr 3 (0xA3).
  - First two are accepted; pend=4'b0110; wr2_ready=0 and addr-3 is held.
  - Drop wr1_en: bank1=0xA1, then bank2=0xA2 on consecutive cycles.
  - addr-3 is accepted once ready rises.
- Kill: buffer holds (2,0x77); wr1 writes (2,0x99) -> entry killed, pend=0, bank2 stays 0x99 after idle cycles.
  - Same-cycle wr2 (1,0x44) with wr1 (1,0x55) -> bank1=0x55 and never 0x44.
- Async reset mid-drain: buffer count 2, assert rst between edges -> banks=0, pend=0, wr2_ready=0 immediately.
  - After release, wr2_ready=1 and no stale write appears.
